// File: rtl/div_ctrl_unit_if.sv
// Handshake and micro-op bus between the division control unit and the
// register bank / ALU datapath it sequences.
interface div_ctrl_unit_if;
    logic       start;
    logic [7:0] InB;
    logic       alu_sign;
    logic       q_msb;
    logic [2:0] InMuxAdd;
    logic [7:0] CUconst;
    logic       WE;
    logic [3:0] RegAdd;
    logic [3:0] OutMuxAdd;
    logic [2:0] AluOp;
    logic       AluCin;
    logic       busy;
    logic       done;
    logic [1:0] err;

    modport master (
        output start, InB, alu_sign, q_msb,
        input  InMuxAdd, CUconst, WE, RegAdd, OutMuxAdd, AluOp, AluCin,
               busy, done, err
    );

    modport slave (
        input  start, InB, alu_sign, q_msb,
        output InMuxAdd, CUconst, WE, RegAdd, OutMuxAdd, AluOp, AluCin,
               busy, done, err
    );
endinterface

// File: rtl/div_ctrl_unit.sv
// Sequencer for an 8-bit unsigned non-restoring division on the 16x8 bank.
// R1 = ALU A, R2 = divisor, R3 = dividend/quotient, R7 = partial remainder.
module div_ctrl_unit #(
    parameter int         N_ITER  = 8,
    parameter logic [2:0] OP_PASS = 3'd0,
    parameter logic [2:0] OP_ADD  = 3'd1,
    parameter logic [2:0] OP_SUB  = 3'd2,
    parameter logic [2:0] OP_SHL  = 3'd3
) (
    input logic            clk,
    input logic            rst,
    div_ctrl_unit_if.slave bus
);
    localparam int CNT_W = $clog2(N_ITER + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LD_D   = 4'd1;
    localparam logic [3:0] S_LD_Q   = 4'd2;
    localparam logic [3:0] S_LD_R   = 4'd3;
    localparam logic [3:0] S_IT_LDA = 4'd4;
    localparam logic [3:0] S_IT_SHA = 4'd5;
    localparam logic [3:0] S_IT_ARI = 4'd6;
    localparam logic [3:0] S_IT_LDQ = 4'd7;
    localparam logic [3:0] S_IT_SHQ = 4'd8;
    localparam logic [3:0] S_FX_LDA = 4'd9;
    localparam logic [3:0] S_FX_ADD = 4'd10;
    localparam logic [3:0] S_DONE   = 4'd11;

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             rsign;
    logic             qbit;
    logic [1:0]       err;
    logic             err_done;

    logic             we;
    logic [2:0]       in_mux;
    logic [3:0]       reg_add;
    logic [3:0]       out_mux;
    logic [2:0]       alu_op;
    logic             alu_cin;
    logic [7:0]       cu_const;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rsign    <= 1'b0;
            qbit     <= 1'b0;
            err      <= 2'b00;
            err_done <= 1'b0;
        end else begin
            err_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Rejected divisors never leave IDLE; done is pulsed from err_done.
                    if (bus.start) begin
                        if (bus.InB == 8'd0) begin
                            err      <= 2'b01;
                            err_done <= 1'b1;
                        end else if (bus.InB[7]) begin
                            err      <= 2'b10;
                            err_done <= 1'b1;
                        end else begin
                            err   <= 2'b00;
                            state <= S_LD_D;
                        end
                    end
                end
                S_LD_D: state <= S_LD_Q;
                S_LD_Q: state <= S_LD_R;
                S_LD_R: begin
                    rsign <= 1'b0;
                    cnt   <= CNT_W'(N_ITER);
                    state <= S_IT_LDA;
                end
                S_IT_LDA: begin
                    qbit  <= bus.q_msb;
                    state <= S_IT_SHA;
                end
                S_IT_SHA: state <= S_IT_ARI;
                S_IT_ARI: begin
                    rsign <= bus.alu_sign;
                    state <= S_IT_LDQ;
                end
                S_IT_LDQ: state <= S_IT_SHQ;
                S_IT_SHQ: begin
                    cnt <= cnt - 1'b1;
                    // Last iteration: a negative remainder needs one corrective add.
                    if (cnt != CNT_W'(1))
                        state <= S_IT_LDA;
                    else if (rsign)
                        state <= S_FX_LDA;
                    else
                        state <= S_DONE;
                end
                S_FX_LDA: begin
                    qbit  <= bus.q_msb;
                    state <= S_FX_ADD;
                end
                S_FX_ADD: state <= S_DONE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        we       = 1'b0;
        in_mux   = 3'd0;
        reg_add  = 4'd0;
        out_mux  = 4'd0;
        alu_op   = OP_PASS;
        alu_cin  = 1'b0;
        cu_const = 8'd0;
        case (state)
            S_LD_D: begin
                we      = 1'b1;
                reg_add = 4'd2;
                in_mux  = 3'd1;
            end
            S_LD_Q: begin
                we      = 1'b1;
                reg_add = 4'd3;
                in_mux  = 3'd0;
            end
            S_LD_R: begin
                we       = 1'b1;
                reg_add  = 4'd7;
                in_mux   = 3'd2;
                cu_const = 8'd0;
            end
            S_IT_LDA, S_FX_LDA: begin
                we      = 1'b1;
                reg_add = 4'd1;
                in_mux  = 3'd4;
                out_mux = 4'd7;
            end
            S_IT_SHA: begin
                we      = 1'b1;
                reg_add = 4'd1;
                in_mux  = 3'd3;
                alu_op  = OP_SHL;
                alu_cin = qbit;
            end
            S_IT_ARI: begin
                we      = 1'b1;
                reg_add = 4'd7;
                in_mux  = 3'd3;
                alu_op  = rsign ? OP_ADD : OP_SUB;
            end
            S_IT_LDQ: begin
                we      = 1'b1;
                reg_add = 4'd1;
                in_mux  = 3'd4;
                out_mux = 4'd3;
            end
            S_IT_SHQ: begin
                we      = 1'b1;
                reg_add = 4'd3;
                in_mux  = 3'd3;
                alu_op  = OP_SHL;
                alu_cin = ~rsign;
            end
            S_FX_ADD: begin
                we      = 1'b1;
                reg_add = 4'd7;
                in_mux  = 3'd3;
                alu_op  = OP_ADD;
            end
            default: ;
        endcase
    end

    assign bus.WE        = we;
    assign bus.InMuxAdd  = in_mux;
    assign bus.RegAdd    = reg_add;
    assign bus.OutMuxAdd = out_mux;
    assign bus.AluOp     = alu_op;
    assign bus.AluCin    = alu_cin;
    assign bus.CUconst   = cu_const;
    assign bus.busy      = (state != S_IDLE) && (state != S_DONE);
    assign bus.done      = (state == S_DONE) || err_done;
    assign bus.err       = err;
endmodule

// File: tb/tb_div_ctrl_unit.sv
// Bench for div_ctrl_unit: models the register bank and ALU around the
// controller and scores results, latency and every micro-op.
module tb_div_ctrl_unit;
    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_ctrl_unit_if bus ();
    div_ctrl_unit dut (.clk(clk), .rst(rst), .bus(bus));

    // Datapath model: 16x8 bank, ALU with A = R1, B = R2
    logic [7:0] rf [16];
    logic [7:0] in_a;
    logic [7:0] alu_out;
    logic [7:0] wdata;

    always_comb begin
        case (bus.AluOp)
            OP_ADD:  alu_out = rf[1] + rf[2];
            OP_SUB:  alu_out = rf[1] - rf[2];
            OP_SHL:  alu_out = {rf[1][6:0], bus.AluCin};
            default: alu_out = rf[1];
        endcase
    end

    always_comb begin
        case (bus.InMuxAdd)
            3'd0:    wdata = in_a;
            3'd1:    wdata = bus.InB;
            3'd2:    wdata = bus.CUconst;
            3'd3:    wdata = alu_out;
            3'd4:    wdata = rf[bus.OutMuxAdd];
            default: wdata = 8'h00;
        endcase
    end

    always @(posedge clk) if (bus.WE) rf[bus.RegAdd] <= wdata;

    assign bus.alu_sign = alu_out[7];
    assign bus.q_msb    = rf[3][7];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic [1:0] err;
        int         lat;
        int         we;
        int         t0;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit nr_fix(input logic [7:0] a, input logic [7:0] d);
        int r  = 0;
        int dd = int'(d);
        for (int i = 7; i >= 0; i--) begin
            int b = int'(a[i]);
            if (r >= 0) r = 2 * r + b - dd;
            else        r = 2 * r + b + dd;
        end
        return r < 0;
    endfunction

    function automatic logic [23:0] uop(input logic we, input logic [2:0] im,
                                        input logic [3:0] ra, input logic [3:0] om,
                                        input logic [2:0] op, input logic cin,
                                        input logic [7:0] k);
        return {we, im, ra, om, op, cin, k};
    endfunction

    // Expected micro-op for the s-th busy cycle, given current R3/R7 sign bits
    function automatic logic [23:0] exp_uop(input int s, input logic r3m, input logic r7m);
        if (s == 0) return uop(1'b1, 3'd1, 4'd2, 4'd0, OP_PASS, 1'b0, 8'd0);
        if (s == 1) return uop(1'b1, 3'd0, 4'd3, 4'd0, OP_PASS, 1'b0, 8'd0);
        if (s == 2) return uop(1'b1, 3'd2, 4'd7, 4'd0, OP_PASS, 1'b0, 8'd0);
        if (s >= 3 && s <= 42) begin
            case ((s - 3) % 5)
                0: return uop(1'b1, 3'd4, 4'd1, 4'd7, OP_PASS, 1'b0, 8'd0);
                1: return uop(1'b1, 3'd3, 4'd1, 4'd0, OP_SHL, r3m, 8'd0);
                2: return uop(1'b1, 3'd3, 4'd7, 4'd0, r7m ? OP_ADD : OP_SUB, 1'b0, 8'd0);
                3: return uop(1'b1, 3'd4, 4'd1, 4'd3, OP_PASS, 1'b0, 8'd0);
                default: return uop(1'b1, 3'd3, 4'd3, 4'd0, OP_SHL, ~r7m, 8'd0);
            endcase
        end
        if (s == 43) return uop(1'b1, 3'd4, 4'd1, 4'd7, OP_PASS, 1'b0, 8'd0);
        if (s == 44) return uop(1'b1, 3'd3, 4'd7, 4'd0, OP_ADD, 1'b0, 8'd0);
        return '1;
    endfunction

    int step     = -1;
    bit prev_bsy = 1'b0;
    int we_cnt   = 0;

    always @(negedge clk) begin : mon
        logic [23:0] obs;
        logic [23:0] expv;
        exp_t        e;
        obs = {bus.WE, bus.InMuxAdd, bus.RegAdd, bus.OutMuxAdd, bus.AluOp,
               bus.AluCin, bus.CUconst};
        if (bus.busy) begin
            step = prev_bsy ? step + 1 : 0;
            expv = exp_uop(step, rf[3][7], rf[7][7]);
        end else begin
            expv = '0;
        end
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL uop t=%0t step=%0d got=%h need=%h", $time, step, obs, expv);
        end
        if (bus.WE) we_cnt++;
        prev_bsy = bus.busy;
        if (rst) begin
            we_cnt = 0;
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done t=%0t got=1 need=0", $time);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (cyc - e.t0 !== e.lat) begin
                    n_bad++;
                    $display("FAIL latency got=%0d need=%0d", cyc - e.t0, e.lat);
                end
                n_cmp++;
                if (bus.err !== e.err) begin
                    n_bad++;
                    $display("FAIL err got=%b need=%b", bus.err, e.err);
                end
                n_cmp++;
                if (we_cnt !== e.we) begin
                    n_bad++;
                    $display("FAIL we_count got=%0d need=%0d", we_cnt, e.we);
                end
                if (e.err == 2'b00) begin
                    n_cmp++;
                    if ({rf[3], rf[7]} !== {e.q, e.r}) begin
                        n_bad++;
                        $display("FAIL result got q=%0d r=%0d need q=%0d r=%0d",
                                 rf[3], rf[7], e.q, e.r);
                    end
                end
            end
            we_cnt = 0;
        end
    end

    task automatic launch(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        bit   fx;
        @(negedge clk);
        in_a      = a;
        bus.InB   = d;
        bus.start = 1'b1;
        e.t0 = cyc;
        e.q  = 8'd0;
        e.r  = 8'd0;
        if (d == 8'd0) begin
            e.err = 2'b01; e.lat = 1; e.we = 0;
        end else if (d >= 8'd128) begin
            e.err = 2'b10; e.lat = 1; e.we = 0;
        end else begin
            fx    = nr_fix(a, d);
            e.err = 2'b00;
            e.q   = a / d;
            e.r   = a % d;
            e.lat = fx ? 46 : 44;
            e.we  = fx ? 45 : 43;
        end
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout got pending=%0d need 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b need=0", bus.busy); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b need=0", bus.done); end
        n_cmp++;
        if (bus.err !== 2'b00) begin n_bad++; $display("FAIL rst_err got=%b need=00", bus.err); end
        n_cmp++;
        if (bus.WE !== 1'b0) begin n_bad++; $display("FAIL rst_we got=%b need=0", bus.WE); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        launch(8'd100, 8'd7);
        wait_drain(80);
    endtask

    task automatic test_fix_path();
        launch(8'd255, 8'd127);
        wait_drain(80);
    endtask

    task automatic test_small();
        launch(8'd0, 8'd5);
        wait_drain(80);
        launch(8'd9, 8'd5);
        wait_drain(80);
    endtask

    task automatic test_errors();
        launch(8'd33, 8'd0);
        wait_drain(10);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.err !== 2'b01) begin n_bad++; $display("FAIL err_hold_dz got=%b need=01", bus.err); end
        launch(8'd33, 8'd200);
        wait_drain(10);
        n_cmp++;
        if (bus.err !== 2'b10) begin n_bad++; $display("FAIL err_hold_big got=%b need=10", bus.err); end
        launch(8'd77, 8'd10);
        wait_drain(80);
        n_cmp++;
        if (bus.err !== 2'b00) begin n_bad++; $display("FAIL err_clear got=%b need=00", bus.err); end
    endtask

    task automatic test_ignored_start();
        int n = 0;
        launch(8'd200, 8'd9);
        repeat (15) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout got=%b need=1", bus.done);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL start_in_done got busy=%b need=0", bus.busy); end
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_bad++;
            $display("FAIL after_done got=%b need=00", {bus.busy, bus.done});
        end
        wait_drain(10);
    endtask

    task automatic test_async_reset();
        int n = 0;
        launch(8'd123, 8'd11);
        while (!(bus.WE && bus.RegAdd == 4'd7 && bus.InMuxAdd == 3'd3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!(bus.WE && bus.RegAdd == 4'd7 && bus.InMuxAdd == 3'd3)) begin
            n_bad++;
            $display("FAIL reach_ari got RegAdd=%0d need 7", bus.RegAdd);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.WE !== 1'b0) begin n_bad++; $display("FAIL arst_we got=%b need=0", bus.WE); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy got=%b need=0", bus.busy); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL arst_done got=%b need=0", bus.done); end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        launch(8'd50, 8'd6);
        wait_drain(80);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.InB   = 8'd0;
        in_a      = 8'd0;
        for (int i = 0; i < 16; i++) rf[i] = 8'd0;
        test_reset();
        test_basic();
        test_fix_path();
        test_small();
        test_errors();
        test_ignored_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
